// File: rtl/flippy_round_scheduler_if.sv
// rtl/flippy_round_scheduler_if.sv - lane/game bus between the round scheduler and its environment
interface flippy_round_scheduler_if;
    logic       start;
    logic       tick;
    logic [2:0] lane_busy;
    logic [2:0] lane_hit;
    logic [2:0] lane_miss;
    logic [2:0] lane_spawn;
    logic [7:0] spawn_value;
    logic       clear_lanes;
    logic [1:0] state;
    logic [7:0] score;
    logic [7:0] best_score;
    logic [1:0] lives;
    logic [2:0] level;
    logic       new_best;

    modport master (
        output start, tick, lane_busy, lane_hit, lane_miss,
        input  lane_spawn, spawn_value, clear_lanes, state, score, best_score, lives, level, new_best
    );

    modport slave (
        input  start, tick, lane_busy, lane_hit, lane_miss,
        output lane_spawn, spawn_value, clear_lanes, state, score, best_score, lives, level, new_best
    );
endinterface

// File: rtl/flippy_round_scheduler.sv
// rtl/flippy_round_scheduler.sv - three-lane target game round scheduler with scoring and lives
module flippy_round_scheduler #(
    parameter int         SPAWN_BASE  = 16,
    parameter int         LEVEL_STEP  = 8,
    parameter int         START_LIVES = 3,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input logic                   clock,
    input logic                   reset_button,
    flippy_round_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;

    localparam int STEP_SHIFT = $clog2(LEVEL_STEP);

    state_t     state_q, state_d;
    logic       enter_play, enter_over, in_play;
    logic [7:0] score_q, score_d, best_q;
    logic [1:0] lives_q, lives_d, miss_count;
    logic [2:0] level_q, level_calc;
    logic       new_best_q;
    logic [1:0] ptr_q;
    logic [4:0] timer_q, reload;
    logic [2:0] spawn_q;
    logic [7:0] lfsr_q;
    logic [8:0] score_sum;
    logic [7:0] level_quot;
    logic [5:0] level_cut, interval;
    logic [1:0] c0, c1, c2, sel;
    logic       found;

    function automatic logic [1:0] pop3(input logic [2:0] v);
        return 2'({1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]});
    endfunction

    function automatic logic [1:0] next3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic lane_free(input logic [2:0] busy, input logic [1:0] p);
        return (p == 2'd0) ? ~busy[0] : (p == 2'd1) ? ~busy[1] : ~busy[2];
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] p);
        return (p == 2'd0) ? 3'b001 : (p == 2'd1) ? 3'b010 : 3'b100;
    endfunction

    assign in_play = (state_q == PLAY);

    // A lane that is both hit and missed in the same cycle counts only as a hit.
    assign score_sum  = 9'(score_q) + 9'(pop3(bus.lane_hit));
    assign score_d    = score_sum[8] ? 8'hFF : score_sum[7:0];
    assign miss_count = pop3(bus.lane_miss & ~bus.lane_hit);
    assign lives_d    = (lives_q > miss_count) ? lives_q - miss_count : 2'd0;

    assign level_quot = score_q >> STEP_SHIFT;
    assign level_calc = (level_quot > 8'd7) ? 3'd7 : level_quot[2:0];

    assign level_cut  = {2'b00, level_q, 1'b0};
    assign interval   = (6'(SPAWN_BASE) > level_cut + 6'd2) ? 6'(SPAWN_BASE) - level_cut : 6'd2;
    assign reload     = 5'(interval - 6'd1);

    // Round-robin search for a free lane starting at the pointer.
    assign c0 = ptr_q;
    assign c1 = next3(c0);
    assign c2 = next3(c1);
    always_comb begin
        found = 1'b1;
        sel   = c0;
        if (lane_free(bus.lane_busy, c0))      sel = c0;
        else if (lane_free(bus.lane_busy, c1)) sel = c1;
        else if (lane_free(bus.lane_busy, c2)) sel = c2;
        else                                   found = 1'b0;
    end

    always_ff @(posedge clock or posedge reset_button) begin
        if (reset_button) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        enter_play = 1'b0;
        enter_over = 1'b0;
        case (state_q)
            PLAY: begin
                if (lives_d == 2'd0) begin
                    state_d    = OVER;
                    enter_over = 1'b1;
                end
            end
            OVER: begin
                if (bus.start) begin
                    state_d    = PLAY;
                    enter_play = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d    = PLAY;
                    enter_play = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset_button) begin
        if (reset_button) begin
            score_q    <= 8'd0;
            best_q     <= 8'd0;
            lives_q    <= 2'd0;
            level_q    <= 3'd0;
            new_best_q <= 1'b0;
            ptr_q      <= 2'd0;
            timer_q    <= 5'd0;
            spawn_q    <= 3'b000;
            lfsr_q     <= LFSR_SEED;
        end else begin
            lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            spawn_q <= 3'b000;
            if (enter_play) begin
                score_q    <= 8'd0;
                lives_q    <= 2'(START_LIVES);
                level_q    <= 3'd0;
                timer_q    <= 5'(SPAWN_BASE - 1);
                ptr_q      <= 2'd0;
                new_best_q <= 1'b0;
            end else begin
                level_q <= level_calc;
                if (in_play) begin
                    score_q <= score_d;
                    lives_q <= lives_d;
                    if (bus.tick) begin
                        if (timer_q == 5'd0) begin
                            timer_q <= reload;
                            if (found) begin
                                spawn_q <= onehot(sel);
                                ptr_q   <= next3(sel);
                            end
                        end else begin
                            timer_q <= timer_q - 5'd1;
                        end
                    end
                end
                if (enter_over && (score_d > best_q)) begin
                    best_q     <= score_d;
                    new_best_q <= 1'b1;
                end
            end
        end
    end

    assign bus.lane_spawn  = spawn_q & {3{in_play}};
    assign bus.spawn_value = lfsr_q;
    assign bus.clear_lanes = ~in_play;
    assign bus.state       = state_q;
    assign bus.score       = score_q;
    assign bus.best_score  = best_q;
    assign bus.lives       = lives_q;
    assign bus.level       = level_q;
    assign bus.new_best    = new_best_q;
endmodule
